// File: rtl/axi4lite_read_master.sv
// Single-outstanding AXI4-Lite read initiator with a sticky watchdog flag.
// Optional AXI_RD_ALIGN_CHECK_EN: misaligned requests answer SLVERR locally without issuing AR.
module axi4lite_read_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        timeout
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        req_hs_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic        rsp_hs_s;
  logic        misalign_s;
  logic [31:0] araddr_r;
  logic [2:0]  arprot_r;
  logic [31:0] rsp_data_r;
  logic [1:0]  rsp_resp_r;
  logic [15:0] wd_cnt_r;
  logic        timeout_r;

  assign req_hs_s = req_valid & req_ready;
  assign ar_hs_s  = arvalid & arready;
  assign r_hs_s   = rvalid & rready;
  assign rsp_hs_s = rsp_valid & rsp_ready;

`ifdef AXI_RD_ALIGN_CHECK_EN
  assign misalign_s = (req_addr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_hs_s) begin
          state_s = misalign_s ? ST_RESP : ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) state_s = ST_DATA;
        else         state_s = ST_ADDR;
      end
      ST_DATA: begin
        if (r_hs_s) state_s = ST_RESP;
        else        state_s = ST_DATA;
      end
      ST_RESP: begin
        if (rsp_hs_s) state_s = ST_IDLE;
        else          state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register
  always_comb begin
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_ADDR: arvalid   = 1'b1;
      ST_DATA: rready    = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Request and response capture; a locally rejected request never touches araddr/arprot
  always_ff @(posedge aclk) begin
    if (areset) begin
      araddr_r   <= 32'd0;
      arprot_r   <= 3'd0;
      rsp_data_r <= 32'd0;
      rsp_resp_r <= 2'b00;
    end else begin
      if (req_hs_s && !misalign_s) begin
        araddr_r <= req_addr;
        arprot_r <= req_prot;
      end
      if (r_hs_s) begin
        rsp_data_r <= rdata;
        rsp_resp_r <= rresp;
      end else if (req_hs_s && misalign_s) begin
        rsp_data_r <= 32'd0;
        rsp_resp_r <= 2'b10;
      end
    end
  end

  // Watchdog: counts silent DATA cycles, flag is sticky until reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_cnt_r  <= 16'd0;
      timeout_r <= 1'b0;
    end else if (ar_hs_s) begin
      wd_cnt_r <= 16'd0;
    end else if ((state_r == ST_DATA) && !rvalid && (wd_cnt_r != TIMEOUT_C)) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
      if (wd_cnt_r == (TIMEOUT_C - 16'd1)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign araddr   = araddr_r;
  assign arprot   = arprot_r;
  assign rsp_data = rsp_data_r;
  assign rsp_resp = rsp_resp_r;
  assign timeout  = timeout_r;

endmodule
